key_led_ctrl: RTL and testbench

Consumer side of the push-button path. It takes the 4-bit one-cycle press strobes from the key debounce driver and drives four board LEDs. Each press on channel i advances LED i through a mode cycle: OFF -> ON -> SLOW blink -> FAST blink -> OFF. Blink timing comes from a shared 1 ms prescaler, so a 20 MHz clock gives 1 ms ticks at the default setting.

---
 rtl/key_led_ctrl.sv | 145 ++++++++++++++
 tb/tb_key_led_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: turns one-cycle key press strobes into per-LED modes
// (OFF -> ON -> SLOW blink -> FAST blink -> OFF) and drives the LED pins.
// Blink timing comes from a shared prescaler tick and two global,
// free-running phase generators.
module key_led_ctrl #(
   parameter int unsigned TICK_DIV       = 20000,
   parameter int unsigned SLOW_TICKS     = 500,
   parameter int unsigned FAST_TICKS     = 125,
   parameter int unsigned LED_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic [3:0] press,
   output logic [3:0] led,
   output logic [7:0] mode,
   output logic       tick
);

   // A divisor of 1 still needs a 1-bit counter; it simply stays at 0.
   localparam int unsigned PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
   localparam int unsigned SW = (SLOW_TICKS > 1) ? $clog2(SLOW_TICKS) : 1;
   localparam int unsigned FW = (FAST_TICKS > 1) ? $clog2(FAST_TICKS) : 1;

   localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] S_MAX = SW'(SLOW_TICKS - 1);
   localparam logic [FW-1:0] F_MAX = FW'(FAST_TICKS - 1);

   localparam logic UNLIT = (LED_ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      M_OFF  = 2'd0,
      M_ON   = 2'd1,
      M_SLOW = 2'd2,
      M_FAST = 2'd3
   } mode_e;

   logic [PW-1:0] pre_cnt;
   logic          tick_r;
   logic [SW-1:0] slow_cnt;
   logic          slow_phase;
   logic [FW-1:0] fast_cnt;
   logic          fast_phase;
   logic [3:0]    press_r;
   logic [3:0]    ev;
   logic [3:0]    lit;
   logic [3:0]    led_r;
   mode_e         mode_r [4];

   // Prescaler: wraps every TICK_DIV clocks; tick is registered one cycle later.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         pre_cnt <= '0;
         tick_r  <= 1'b0;
      end else begin
         tick_r  <= (pre_cnt == P_MAX);
         pre_cnt <= (pre_cnt == P_MAX) ? '0 : pre_cnt + PW'(1);
      end
   end

   // Slow blink phase: toggles each SLOW_TICKS ticks.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         slow_cnt   <= '0;
         slow_phase <= 1'b0;
      end else if (tick_r) begin
         if (slow_cnt == S_MAX) begin
            slow_cnt   <= '0;
            slow_phase <= ~slow_phase;
         end else begin
            slow_cnt <= slow_cnt + SW'(1);
         end
      end
   end

   // Fast blink phase: toggles each FAST_TICKS ticks.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         fast_cnt   <= '0;
         fast_phase <= 1'b0;
      end else if (tick_r) begin
         if (fast_cnt == F_MAX) begin
            fast_cnt   <= '0;
            fast_phase <= ~fast_phase;
         end else begin
            fast_cnt <= fast_cnt + FW'(1);
         end
      end
   end

   // Rising-edge detect so a held strobe counts as a single press.
   always_comb begin
      ev = press & ~press_r;
   end

   // Press history and per-channel mode advance (3 wraps to 0 naturally).
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         press_r <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            mode_r[i] <= M_OFF;
         end
      end else begin
         press_r <= press;
         for (int unsigned i = 0; i < 4; i++) begin
            if (ev[i]) begin
               mode_r[i] <= mode_e'(mode_r[i] + 2'd1);
            end
         end
      end
   end

   // Lit condition per channel from its mode and the global blink phases.
   always_comb begin
      lit = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         case (mode_r[i])
            M_OFF:  lit[i] = 1'b0;
            M_ON:   lit[i] = 1'b1;
            M_SLOW: lit[i] = slow_phase;
            M_FAST: lit[i] = fast_phase;
         endcase
      end
   end

   // Registered LED pin drive with board polarity applied.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         led_r <= {4{UNLIT}};
      end else begin
         led_r <= lit ^ {4{UNLIT}};
      end
   end

   // Pack per-channel modes onto the flat mode bus.
   always_comb begin
      mode = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         mode[2*i +: 2] = mode_r[i];
      end
   end

   assign led  = led_r;
   assign tick = tick_r;

endmodule

// File: tb/tb_key_led_ctrl.sv
// tb_key_led_ctrl: scoreboard bench for key_led_ctrl. The stimulus process
// drives press patterns and pushes the reference model's expected outputs;
// a monitor pops one entry per clock and compares.
module tb_key_led_ctrl;

   localparam int unsigned TD   = 4;
   localparam int unsigned SLOW = 4;
   localparam int unsigned FAST = 2;

   logic       clk = 1'b0;
   logic       n_reset;
   logic [3:0] press;
   logic [3:0] led;
   logic [7:0] mode;
   logic       tick;

   key_led_ctrl #(
      .TICK_DIV       (TD),
      .SLOW_TICKS     (SLOW),
      .FAST_TICKS     (FAST),
      .LED_ACTIVE_LOW (1)
   ) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .press   (press),
      .led     (led),
      .mode    (mode),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] mode;
      logic [3:0] led;
      logic       tick;
   } exp_t;

   exp_t q[$];

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // Reference model state: edges since reset release, press history and
   // the number of press events seen per channel.
   int unsigned k;
   logic [3:0]  prev_p;
   int unsigned presses [4];
   int unsigned mode_prev [4];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Blink phase after rising edge j: ticks appear after edges TD, 2TD, ...
   // and each is consumed on the following edge; the phase flips every n ticks.
   function automatic logic phase_at(input int unsigned j, input int unsigned n);
      if (j == 0) return 1'b0;
      return ((((j - 1) / TD) / n) % 2) == 1;
   endfunction

   function automatic logic lit_of(input int unsigned m, input int unsigned j);
      case (m)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return phase_at(j, SLOW);
         default: return phase_at(j, FAST);
      endcase
   endfunction

   // Drive a press pattern for the coming edge and push the expected result.
   task automatic drive_edge(input logic [3:0] p);
      exp_t e;
      logic [3:0] ev;
      press = p;
      ev = p & ~prev_p;
      prev_p = p;
      k++;
      for (int i = 0; i < 4; i++) begin
         e.led[i] = ~lit_of(mode_prev[i], k - 1);
         presses[i] += ev[i] ? 1 : 0;
         mode_prev[i] = presses[i] % 4;
         e.mode[2*i +: 2] = 2'(mode_prev[i]);
      end
      e.tick = (k % TD) == 0;
      q.push_back(e);
   endtask

   task automatic step(input logic [3:0] p);
      @(negedge clk);
      drive_edge(p);
   endtask

   task automatic pulse(input logic [3:0] p, input int unsigned gap);
      step(p);
      repeat (gap - 1) step(4'b0000);
   endtask

   // Assert reset for some cycles while toggling press, check the reset
   // state directly, then release and restart the model.
   task automatic do_reset(input int unsigned cycles);
      @(negedge clk);
      n_reset = 1'b0;
      press = 4'($urandom);
      #1;
      chk("rst_mode", mode, 8'h00);
      chk("rst_led", {4'h0, led}, 8'h0F);
      chk("rst_tick", {7'h0, tick}, 8'h00);
      repeat (cycles) begin
         @(negedge clk);
         press = 4'($urandom);
         #1;
         chk("rst_hold_mode", mode, 8'h00);
         chk("rst_hold_led", {4'h0, led}, 8'h0F);
         chk("rst_hold_tick", {7'h0, tick}, 8'h00);
      end
      @(negedge clk);
      n_reset = 1'b1;
      k = 0;
      prev_p = '0;
      for (int i = 0; i < 4; i++) begin
         presses[i] = 0;
         mode_prev[i] = 0;
      end
      drive_edge(4'b0000);
   endtask

   // Monitor: one expected entry per clock while out of reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("mode", mode, e.mode);
            chk("led", {4'h0, led}, {4'h0, e.led});
            chk("tick", {7'h0, tick}, {7'h0, e.tick});
         end
      end
   end

   initial begin
      int unsigned rst_at;
      logic [3:0] p;
      n_reset = 1'b0;
      press = '0;
      k = 0;
      prev_p = '0;
      for (int i = 0; i < 4; i++) begin
         presses[i] = 0;
         mode_prev[i] = 0;
      end

      // Reset, then single-channel full mode cycle.
      do_reset(3);
      repeat (4) pulse(4'b0001, 40);

      // Held strobe counts once.
      do_reset(1);
      repeat (50) step(4'b0100);
      repeat (10) step(4'b0000);

      // Simultaneous presses on all channels.
      do_reset(1);
      pulse(4'b1111, 10);
      pulse(4'b1111, 40);

      // Wrap and independence.
      do_reset(1);
      repeat (5) pulse(4'b0010, 6);
      repeat (2) pulse(4'b1000, 6);
      repeat (5) step(4'b0000);

      // Reset while all channels blink FAST.
      do_reset(1);
      repeat (3) pulse(4'b1111, 3);
      repeat (13) step(4'b0000);
      do_reset(1);
      repeat (20) step(4'b0000);

      // Randomized sparse presses with one reset at a random point.
      rst_at = $urandom_range(200, 1300);
      for (int unsigned n = 0; n < 1500; n++) begin
         if (n == rst_at) do_reset($urandom_range(0, 2));
         for (int i = 0; i < 4; i++) p[i] = ($urandom_range(0, 7) == 0);
         step(p);
      end

      repeat (3) step(4'b0000);
      repeat (2) @(negedge clk);
      chk("drain", 8'(q.size()), 8'h00);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
